// File: rtl/subtractor_seq_pkg.sv
// ----------------------------------------------------------------------------
// subtractor_seq_pkg
// Shared definitions for the multi-cycle chunked subtractor:
//   - state_t      : controller state encoding (IDLE / RUN / DONE)
//   - nch_of()     : number of chunks an operand splits into
//   - cnt_width()  : width of a counter/index able to address n items, >= 1
// ----------------------------------------------------------------------------
package subtractor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nch_of(input int size, input int chunk);
        return size / chunk;
    endfunction

    // A one-item range still needs a one-bit register, hence the floor of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtractor_seq_if.sv
// ----------------------------------------------------------------------------
// subtractor_seq_if
// Request/result bundle of the chunked subtractor.
//   start        request, sampled by the subtractor only when busy=0
//   A, B         minuend / subtrahend, sampled together with start
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   DIFF         A - B mod 2^SIZE
//   bout         unsigned borrow (A < B unsigned)
//   ovf          signed overflow
//   zero         DIFF == 0
// Modports: master = requester, slave = subtractor.
// ----------------------------------------------------------------------------
interface subtractor_seq_if #(
    parameter int SIZE = 32
);
    logic            start;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] DIFF;
    logic            bout;
    logic            ovf;
    logic            zero;

    modport master (
        output start, A, B,
        input  busy, done, DIFF, bout, ovf, zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, DIFF, bout, ovf, zero
    );
endinterface

// File: rtl/subtractor_seq_sub_chunk.sv
// ----------------------------------------------------------------------------
// FA_str    : single-bit full-adder cell (s = a^b^cin, cout = majority).
// sub_chunk : purely combinational W-bit ripple of FA_str cells computing
//             a + ~b + cin, i.e. a - b when cin=1.
//   a, b  [W-1:0]  operand slices
//   cin            incoming carry (1 = no borrow pending)
//   diff  [W-1:0]  slice result
//   cout           outgoing carry (0 = borrow out of this slice)
// ----------------------------------------------------------------------------
module FA_str (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] diff,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            FA_str u_fa (
                .a    (a[gi]),
                .b    (~b[gi]),
                .cin  (c[gi]),
                .s    (diff[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    assign cout = c[W];
endmodule

// File: rtl/subtractor_seq.sv
// ----------------------------------------------------------------------------
// subtractor_seq
// Multi-cycle two's-complement subtractor: DIFF = A - B, CHUNK bits per clock,
// least significant chunk first, carry kept in a register between chunks.
// Latency SIZE/CHUNK cycles from the start edge to the done pulse; a new
// start is accepted in the DONE cycle, giving back-to-back throughput.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    subtractor_seq_if.slave (start/A/B in, busy/done/DIFF/bout/ovf/zero out)
// SIZE must be a multiple of CHUNK and must match the interface SIZE.
// ----------------------------------------------------------------------------
module subtractor_seq
    import subtractor_seq_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    subtractor_seq_if.slave       bus
);
    localparam int NCH = nch_of(SIZE, CHUNK);
    localparam int CW  = cnt_width(NCH);
    localparam int IW  = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST_K = CW'(NCH - 1);

    state_t          state_reg;
    logic [SIZE-1:0] a_reg;
    logic [SIZE-1:0] b_reg;
    logic [SIZE-1:0] part_reg;
    logic            carry_reg;
    logic [CW-1:0]   k_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [SIZE-1:0] diff_reg;
    logic            bout_reg;
    logic            ovf_reg;
    logic            zero_reg;

    logic [IW-1:0]    base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] chunk_diff;
    logic             chunk_cout;
    logic [SIZE-1:0]  part_next;
    logic             ovf_next;

    // B is kept as given; the inversion for A + ~B + 1 lives in the
    // FA_str ripple inside sub_chunk.
    always_comb begin
        base      = IW'(int'(k_reg) * CHUNK);
        a_slice   = a_reg[base +: CHUNK];
        b_slice   = b_reg[base +: CHUNK];
        part_next = part_reg;
        part_next[base +: CHUNK] = chunk_diff;
        // Overflow only possible when operand signs differ; it occurred if
        // the result sign disagrees with the minuend sign.
        ovf_next  = (a_reg[SIZE-1] != b_reg[SIZE-1]) &&
                    (part_next[SIZE-1] != a_reg[SIZE-1]);
    end

    sub_chunk #(.W(CHUNK)) u_sub_chunk (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_reg),
        .diff (chunk_diff),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            part_reg  <= '0;
            carry_reg <= 1'b1;
            k_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    part_reg  <= part_next;
                    carry_reg <= chunk_cout;
                    k_reg     <= k_reg + CW'(1);
                    if (k_reg == LAST_K) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        diff_reg  <= part_next;
                        bout_reg  <= ~chunk_cout;
                        ovf_reg   <= ovf_next;
                        zero_reg  <= (part_next == '0);
                    end
                end
                // IDLE and DONE both accept a request; DONE is only ever
                // one cycle long, so done always drops here.
                default: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.A;
                        b_reg     <= bus.B;
                        k_reg     <= '0;
                        carry_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.DIFF = diff_reg;
    assign bus.bout = bout_reg;
    assign bus.ovf  = ovf_reg;
    assign bus.zero = zero_reg;

endmodule

// File: tb/tb_subtractor_seq.sv
// ----------------------------------------------------------------------------
// tb_subtractor_seq
// Self-checking bench for subtractor_seq (SIZE=32, CHUNK=8). Expected results
// are pushed to a scoreboard queue when an operation is accepted and popped
// when done pulses. Vector table plus hand-written reset / ignore-start /
// back-to-back / mid-operation-reset sequences.
// ----------------------------------------------------------------------------
module tb_subtractor_seq;

    localparam int SIZE  = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = SIZE / CHUNK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_diff;
    exp_t sb_q[$];

    subtractor_seq_if #(.SIZE(SIZE)) bus ();

    subtractor_seq #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        e.zero = z;
        sb_q.push_back(e);
    endtask

    // Reference arithmetic from the definitions of the outputs.
    task automatic push_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        push_exp(d, (a < b), (a[31] != b[31]) && (d[31] != a[31]), (d == 32'd0));
    endtask

    // Present a request for one edge; returns the edge count of acceptance.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int e0);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
        check("accept_busy", 64'(bus.busy), 64'd1);
        check("diff_hold_at_start", 64'(bus.DIFF), 64'(last_diff));
    endtask

    task automatic wait_done(input int e0, input string tag);
        bit   got;
        exp_t e;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (!got) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        check({tag, "_latency"}, 64'(cyc - e0), 64'(NCH));
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_diff"}, 64'(bus.DIFF), 64'(e.diff));
            check({tag, "_flags"}, 64'({bus.bout, bus.ovf, bus.zero}),
                  64'({e.bout, e.ovf, e.zero}));
            last_diff = e.diff;
        end
        $display("[TB] %s: A=0x%08h B=0x%08h DIFF=0x%08h bout=%0b ovf=%0b zero=%0b",
                 tag, bus.A, bus.B, bus.DIFF, bus.bout, bus.ovf, bus.zero);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int  e0;
        int  e1;
        bit  seen;
        logic [31:0] ra;
        logic [31:0] rb;

        n_tests   = 0;
        n_fail    = 0;
        last_diff = 32'd0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0001_0000, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        // Reset held with start asserted: everything stays cleared.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.A     = 32'd5;
        bus.B     = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ctrl", 64'({bus.busy, bus.done, bus.bout, bus.ovf, bus.zero}), 64'd0);
            check("rst_diff", 64'(bus.DIFF), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // start still high: first edge after release accepts the request.
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc;
        check("post_rst_accept", 64'(bus.busy), 64'd1);
        push_model(32'd5, 32'd3);
        wait_done(e0, "post_rst");

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, e0);
            push_exp(vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero);
            wait_done(e0, $sformatf("vec%0d", i));
        end

        // start during RUN is ignored.
        start_op(32'h1234_5678, 32'h1234_5678, e0);
        push_exp(32'd0, 1'b0, 1'b0, 1'b1);
        bus.A = 32'd9;
        bus.B = 32'd3;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(e0, "ignore_run");
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        check("ignore_no_second_op", 64'(seen), 64'd0);
        check("ignore_diff_hold", 64'(bus.DIFF), 64'd0);

        // Back-to-back: second request held through the DONE cycle.
        start_op(32'd10, 32'd3, e0);
        push_model(32'd10, 32'd3);
        bus.A = 32'd3;
        bus.B = 32'd10;
        bus.start = 1'b1;
        wait_done(e0, "b2b_first");
        // wait_done returned one negedge after the DONE edge.
        e1 = cyc;
        bus.start = 1'b0;
        check("b2b_second_accept", 64'(bus.busy), 64'd1);
        push_exp(32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
        wait_done(e1, "b2b_second");

        // Random operations against the model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? ra - 32'($urandom_range(0, 300)) : $urandom;
            start_op(ra, rb, e0);
            push_model(ra, rb);
            wait_done(e0, $sformatf("rand%0d", i));
        end

        // Reset in the middle of an operation.
        start_op(32'd50, 32'd20, e0);
        push_model(32'd50, 32'd20);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_diff", 64'(bus.DIFF), 64'd0);
        sb_q.delete();
        last_diff = 32'd0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            if (i == 2) rst_n = 1'b1;
        end
        check("midrst_no_done", 64'(seen), 64'd0);
        start_op(32'd50, 32'd20, e0);
        push_exp(32'd30, 1'b0, 1'b0, 1'b0);
        wait_done(e0, "midrst_after");

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
